riscv_decode_q: RTL and testbench

Parametrised, buffered integer-ALU instruction decoder for the RISC-V core's decode stage. Accepts 32-bit instruction words on a valid/ready handshake and decodes both OP-IMM (I-type) and OP (R-type) formats. Decodes invalid encodings to a flagged NOP and counts them. Results go into a DEPTH-entry FIFO that feeds the execute stage over a second valid/ready handshake. It generalises the earlier immediate-only decoder to XLEN 32/64, adds register-register decode, strict shift-encoding checks, buffering, flush and error accounting.

---
 rtl/riscv_decode_q.sv | 231 +++++++++++++++++++++++
 tb/tb_riscv_decode_q.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_q.sv
// riscv_decode_q: buffered OP-IMM / OP instruction decoder.
// Decodes one 32-bit word per accepted handshake into a small record and
// queues it in a DEPTH-entry FIFO for the execute stage. Illegal encodings
// become a flagged NOP and bump a saturating counter.

`ifndef RISCV_ALU_DEFINES
`define RISCV_ALU_DEFINES
`define ADD   5'd0
`define SUB   5'd1
`define SLL   5'd2
`define SLT   5'd3
`define SLTU  5'd4
`define XOR   5'd5
`define SRL   5'd6
`define SRA   5'd7
`define OR    5'd8
`define AND   5'd9
`define ADDI  5'd10
`define SLTI  5'd11
`define SLTIU 5'd12
`define XORI  5'd13
`define ORI   5'd14
`define ANDI  5'd15
`define SLLI  5'd16
`define SRLI  5'd17
`define SRAI  5'd18
`endif

module riscv_decode_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0]       out_rd_o,
    output logic [4:0]       out_rs1_o,
    output logic [4:0]       out_rs2_o,
    output logic [XLEN-1:0]  out_imm_o,
    output logic [4:0]       out_alu_control_o,
    output logic             out_use_imm_o,
    output logic             out_illegal_o,
    output logic [CNT_W-1:0] illegal_count_o
);

    // Shift amount width and the width of the bits above it in the I-immediate.
    localparam int SH  = (XLEN == 64) ? 6 : 5;
    localparam int HIW = 12 - SH;
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    // Arithmetic-shift marker: 0100000 for RV32, 010000 for RV64.
    localparam logic [HIW-1:0] SRA_PAT = {2'b01, {(HIW-2){1'b0}}};

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu;
        logic            use_imm;
        logic            illegal;
    } entry_t;

    // Instruction fields
    logic [6:0]      opcode;
    logic [4:0]      f_rd, f_rs1, f_rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [HIW-1:0]  shift_hi;
    logic [XLEN-1:0] imm_i, shamt_ext;

    assign opcode    = in_instr_i[6:0];
    assign f_rd      = in_instr_i[11:7];
    assign funct3    = in_instr_i[14:12];
    assign f_rs1     = in_instr_i[19:15];
    assign f_rs2     = in_instr_i[24:20];
    assign funct7    = in_instr_i[31:25];
    assign shift_hi  = in_instr_i[31:20+SH];
    assign imm_i     = {{(XLEN-12){in_instr_i[31]}}, in_instr_i[31:20]};
    assign shamt_ext = {{(XLEN-SH){1'b0}}, in_instr_i[20+SH-1:20]};

    entry_t dec;
    logic   legal;

    // Combinational decode of the incoming word; illegal cases collapse to a NOP.
    always_comb begin
        dec         = '0;
        dec.alu     = `ADDI;
        dec.use_imm = 1'b1;
        legal       = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                legal       = 1'b1;
                dec.rd      = f_rd;
                dec.rs1     = f_rs1;
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                case (funct3)
                    3'd0: dec.alu = `ADDI;
                    3'd2: dec.alu = `SLTI;
                    3'd3: dec.alu = `SLTIU;
                    3'd4: dec.alu = `XORI;
                    3'd6: dec.alu = `ORI;
                    3'd7: dec.alu = `ANDI;
                    3'd1: begin
                        dec.alu = `SLLI;
                        dec.imm = shamt_ext;
                        legal   = (shift_hi == '0);
                    end
                    3'd5: begin
                        dec.imm = shamt_ext;
                        if (shift_hi == '0)
                            dec.alu = `SRLI;
                        else if (shift_hi == SRA_PAT)
                            dec.alu = `SRAI;
                        else
                            legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                legal       = 1'b1;
                dec.rd      = f_rd;
                dec.rs1     = f_rs1;
                dec.rs2     = f_rs2;
                dec.use_imm = 1'b0;
                dec.imm     = '0;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0: dec.alu = `ADD;
                        3'd1: dec.alu = `SLL;
                        3'd2: dec.alu = `SLT;
                        3'd3: dec.alu = `SLTU;
                        3'd4: dec.alu = `XOR;
                        3'd5: dec.alu = `SRL;
                        3'd6: dec.alu = `OR;
                        default: dec.alu = `AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                    dec.alu = `SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                    dec.alu = `SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.alu     = `ADDI;
            dec.use_imm = 1'b1;
            dec.illegal = 1'b1;
        end
    end

    // FIFO state
    entry_t            mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full, empty, push, pop;
    entry_t            head;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    // Flush wins over both handshakes so a same-cycle word is dropped entirely.
    assign push  = in_valid_i && !full && !flush_i;
    assign pop   = out_ready_i && !empty && !flush_i;

    // Next-state for pointers and the saturating illegal counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && dec.illegal && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as all-zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= dec;
        end
    end

    assign head              = mem_q[rd_ptr_q[AW-1:0]];
    assign in_ready_o        = !full;
    assign out_valid_o       = !empty;
    assign out_rd_o          = head.rd;
    assign out_rs1_o         = head.rs1;
    assign out_rs2_o         = head.rs2;
    assign out_imm_o         = head.imm;
    assign out_alu_control_o = head.alu;
    assign out_use_imm_o     = head.use_imm;
    assign out_illegal_o     = head.illegal;
    assign illegal_count_o   = cnt_q;

endmodule

// File: tb/tb_riscv_decode_q.sv
// Directed bench for riscv_decode_q: table of decode vectors on an RV32
// instance (DEPTH=2, CNT_W=2) and an RV64 instance, plus hand-written
// sequences for fill/backpressure, counter saturation, flush and reset.

module tb_riscv_decode_q;

    localparam logic [4:0] A_ADD = 5'd0,  A_SUB = 5'd1,  A_SLL = 5'd2,  A_SLT = 5'd3;
    localparam logic [4:0] A_SLTU = 5'd4, A_XOR = 5'd5,  A_SRL = 5'd6,  A_SRA = 5'd7;
    localparam logic [4:0] A_OR = 5'd8,   A_AND = 5'd9,  A_ADDI = 5'd10, A_SLTI = 5'd11;
    localparam logic [4:0] A_SLTIU = 5'd12, A_XORI = 5'd13, A_ORI = 5'd14, A_ANDI = 5'd15;
    localparam logic [4:0] A_SLLI = 5'd16, A_SRLI = 5'd17, A_SRAI = 5'd18;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic [4:0]  alu;
        logic        ui, ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst, flush;

    // RV32 instance
    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [31:0] instr_a;
    logic [4:0]  rd_a, rs1_a, rs2_a, alu_a;
    logic [31:0] imm_a;
    logic        ui_a, ill_a;
    logic [1:0]  cnt_a;

    // RV64 instance
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [31:0] instr_b;
    logic [4:0]  rd_b, rs1_b, rs2_b, alu_b;
    logic [63:0] imm_b;
    logic        ui_b, ill_b;
    logic [7:0]  cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt;
    vec_t tv[$];
    vec_t tv64[$];

    always #5 clk = ~clk;

    riscv_decode_q #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .in_instr_i(instr_a),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready_a),
        .out_rd_o(rd_a), .out_rs1_o(rs1_a), .out_rs2_o(rs2_a), .out_imm_o(imm_a),
        .out_alu_control_o(alu_a), .out_use_imm_o(ui_a), .out_illegal_o(ill_a),
        .illegal_count_o(cnt_a)
    );

    riscv_decode_q #(.XLEN(64), .DEPTH(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .in_instr_i(instr_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
        .out_rd_o(rd_b), .out_rs1_o(rs1_b), .out_rs2_o(rs2_b), .out_imm_o(imm_b),
        .out_alu_control_o(alu_b), .out_use_imm_o(ui_b), .out_illegal_o(ill_b),
        .illegal_count_o(cnt_b)
    );

    function automatic vec_t mk(input logic [31:0] i, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [63:0] imm, input logic [4:0] alu,
                                input logic ui, input logic ill);
        vec_t v;
        v.instr = i; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.alu = alu; v.ui = ui; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head_a(input string tag, input vec_t v);
        chk({tag, ".rd"},  rd_a,  v.rd);
        chk({tag, ".rs1"}, rs1_a, v.rs1);
        chk({tag, ".rs2"}, rs2_a, v.rs2);
        chk({tag, ".imm"}, imm_a, v.imm[31:0]);
        chk({tag, ".alu"}, alu_a, v.alu);
        chk({tag, ".ui"},  ui_a,  v.ui);
        chk({tag, ".ill"}, ill_a, v.ill);
    endtask

    task automatic chk_head_b(input string tag, input vec_t v);
        chk({tag, ".rd"},  rd_b,  v.rd);
        chk({tag, ".rs1"}, rs1_b, v.rs1);
        chk({tag, ".rs2"}, rs2_b, v.rs2);
        chk({tag, ".imm"}, imm_b, v.imm);
        chk({tag, ".alu"}, alu_b, v.alu);
        chk({tag, ".ui"},  ui_b,  v.ui);
        chk({tag, ".ill"}, ill_b, v.ill);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        vec_t nop;
        nop = mk(32'h0, 5'd0, 5'd0, 5'd0, 64'h0, A_ADDI, 1'b1, 1'b1);

        // RV32 vectors: instr, rd, rs1, rs2, imm, alu, use_imm, illegal
        tv.push_back(mk(32'hFFF10093, 1, 2, 0, 64'hFFFFFFFF, A_ADDI, 1, 0));
        tv.push_back(mk(32'h40335293, 5, 6, 0, 64'h3, A_SRAI, 1, 0));
        tv.push_back(mk(32'h44335293, 0, 0, 0, 64'h0, A_ADDI, 1, 1));
        tv.push_back(mk(32'h402081B3, 3, 1, 2, 64'h0, A_SUB, 0, 0));
        tv.push_back(mk(32'h00000073, 0, 0, 0, 64'h0, A_ADDI, 1, 1));
        tv.push_back(mk(32'h003100B3, 1, 2, 3, 64'h0, A_ADD, 0, 0));
        tv.push_back(mk(32'h01F11093, 1, 2, 0, 64'd31, A_SLLI, 1, 0));
        tv.push_back(mk(32'h03F11093, 0, 0, 0, 64'h0, A_ADDI, 1, 1));
        tv.push_back(mk(32'h00415093, 1, 2, 0, 64'd4, A_SRLI, 1, 0));
        tv.push_back(mk(32'h7FF47393, 7, 8, 0, 64'h7FF, A_ANDI, 1, 0));
        tv.push_back(mk(32'h80053493, 9, 10, 0, 64'hFFFFF800, A_SLTIU, 1, 0));
        tv.push_back(mk(32'h4062D233, 4, 5, 6, 64'h0, A_SRA, 0, 0));
        tv.push_back(mk(32'h40209133, 0, 0, 0, 64'h0, A_ADDI, 1, 1));
        tv.push_back(mk(32'h022081B3, 0, 0, 0, 64'h0, A_ADDI, 1, 1));
        tv.push_back(mk(32'h003130B3, 1, 2, 3, 64'h0, A_SLTU, 0, 0));
        tv.push_back(mk(32'h0FF04093, 1, 0, 0, 64'hFF, A_XORI, 1, 0));

        // RV64 vectors: 6-bit shamt, 6-bit SRAI marker, 64-bit sign extension
        tv64.push_back(mk(32'h03F11093, 1, 2, 0, 64'd63, A_SLLI, 1, 0));
        tv64.push_back(mk(32'h42115093, 1, 2, 0, 64'd33, A_SRAI, 1, 0));
        tv64.push_back(mk(32'hFFF10093, 1, 2, 0, 64'hFFFFFFFF_FFFFFFFF, A_ADDI, 1, 0));
        tv64.push_back(mk(32'h04011093, 0, 0, 0, 64'h0, A_ADDI, 1, 1));
        tv64.push_back(mk(32'h00115093, 1, 2, 0, 64'd1, A_SRLI, 1, 0));

        rst = 1'b1; flush = 1'b0;
        in_valid_a = 1'b0; instr_a = '0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; instr_b = '0; out_ready_b = 1'b1;
        #12;
        chk("rst.out_valid", out_valid_a, 0);
        chk("rst.in_ready",  in_ready_a, 1);
        chk("rst.cnt",       cnt_a, 0);
        chk_head_a("rst", mk(32'h0, 0, 0, 0, 64'h0, 5'd0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Table sweep on RV32: push one word, check the head, let it drain.
        exp_cnt = 0;
        foreach (tv[i]) begin
            in_valid_a = 1'b1; instr_a = tv[i].instr;
            tick;
            in_valid_a = 1'b0;
            if (tv[i].ill && exp_cnt < 3) exp_cnt++;
            chk($sformatf("v%0d.valid", i), out_valid_a, 1);
            chk_head_a($sformatf("v%0d", i), tv[i]);
            chk($sformatf("v%0d.cnt", i), cnt_a, exp_cnt);
            tick;
            chk($sformatf("v%0d.drain", i), out_valid_a, 0);
        end

        // Table sweep on RV64.
        foreach (tv64[i]) begin
            in_valid_b = 1'b1; instr_b = tv64[i].instr;
            tick;
            in_valid_b = 1'b0;
            chk($sformatf("w%0d.valid", i), out_valid_b, 1);
            chk_head_b($sformatf("w%0d", i), tv64[i]);
            tick;
            chk($sformatf("w%0d.drain", i), out_valid_b, 0);
        end

        // Counter saturation at 3 with back-to-back illegal pushes.
        do_reset;
        in_valid_a = 1'b1; instr_a = 32'h00000073; out_ready_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("sat%0d.cnt", k), cnt_a, (k < 3) ? k + 1 : 3);
            chk_head_a($sformatf("sat%0d", k), nop);
        end
        in_valid_a = 1'b0;
        tick;

        // Fill with out_ready low, then drain: order kept, one per cycle.
        do_reset;
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; instr_a = 32'h00000093;   // addi x1,x0,0
        tick;
        chk("fill1.in_ready", in_ready_a, 1);
        chk("fill1.valid", out_valid_a, 1);
        instr_a = 32'h00000113;                       // addi x2,x0,0
        tick;
        chk("fill2.in_ready", in_ready_a, 0);
        instr_a = 32'h00000193;                       // addi x3,x0,0 (held)
        tick;
        chk("fill3.in_ready", in_ready_a, 0);
        chk("fill3.rd", rd_a, 1);
        out_ready_a = 1'b1;
        tick;                                         // pop only, full blocked push
        chk("drain1.rd", rd_a, 2);
        chk("drain1.in_ready", in_ready_a, 1);
        tick;                                         // push C + pop B together
        in_valid_a = 1'b0;
        chk("drain2.rd", rd_a, 3);
        chk("drain2.valid", out_valid_a, 1);
        tick;
        chk("drain3.valid", out_valid_a, 0);

        // Flush with two entries buffered and in_valid high.
        do_reset;
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; instr_a = 32'h00000093;
        tick;
        instr_a = 32'h00000113;
        tick;
        flush = 1'b1; instr_a = 32'h00000073;
        tick;
        flush = 1'b0; in_valid_a = 1'b0;
        chk("flush2.valid", out_valid_a, 0);
        chk("flush2.in_ready", in_ready_a, 1);
        chk("flush2.cnt", cnt_a, 0);
        // Flush with one entry and an acceptable illegal push: push dropped.
        in_valid_a = 1'b1; instr_a = 32'h00000093;
        tick;
        flush = 1'b1; instr_a = 32'h00000073;
        tick;
        flush = 1'b0; in_valid_a = 1'b0;
        chk("flush1.valid", out_valid_a, 0);
        chk("flush1.cnt", cnt_a, 0);
        out_ready_a = 1'b1;
        in_valid_a = 1'b1; instr_a = 32'h00000193;
        tick;
        in_valid_a = 1'b0;
        chk("postflush.valid", out_valid_a, 1);
        chk("postflush.rd", rd_a, 3);
        tick;

        // Asynchronous reset mid-stream clears outputs immediately.
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; instr_a = 32'h00000073;
        tick;
        in_valid_a = 1'b0;
        chk("pre_rst.ill", ill_a, 1);
        chk("pre_rst.cnt", cnt_a, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", out_valid_a, 0);
        chk("arst.in_ready", in_ready_a, 1);
        chk("arst.cnt", cnt_a, 0);
        chk_head_a("arst", mk(32'h0, 0, 0, 0, 64'h0, 5'd0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready_a = 1'b1;
        in_valid_a = 1'b1; instr_a = tv[0].instr;
        tick;
        in_valid_a = 1'b0;
        chk("post_rst.valid", out_valid_a, 1);
        chk_head_a("post_rst", tv[0]);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
